// File: rtl/cpu_sequencer_if.sv
// Handshake and strobe bundle between the multi-cycle CPU sequencer and the datapath/instruction memory.
interface cpu_sequencer_if #(
  parameter int OP_W  = 6,
  parameter int CNT_W = 32
);
  logic             start_i;
  logic [OP_W-1:0]  op_i;
  logic             regwrite_i;
  logic             imem_ack_i;
  logic             imem_req_o;
  logic             ir_we_o;
  logic             pc_we_o;
  logic             reg_we_o;
  logic             busy_o;
  logic             halted_o;
  logic             illegal_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] retired_o;

  modport master (
    input  start_i, op_i, regwrite_i, imem_ack_i,
    output imem_req_o, ir_we_o, pc_we_o, reg_we_o, busy_o, halted_o, illegal_o, state_o, retired_o
  );

  modport slave (
    output start_i, op_i, regwrite_i, imem_ack_i,
    input  imem_req_o, ir_we_o, pc_we_o, reg_we_o, busy_o, halted_o, illegal_o, state_o, retired_o
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control FSM: gates IR, PC and register-file writes,
// stops on halt/illegal opcodes and counts retired instructions.
module cpu_sequencer #(
  parameter int              OP_W    = 6,
  parameter int              CNT_W   = 32,
  parameter logic [OP_W-1:0] HALT_OP = 6'b111111
) (
  input  logic            clk_i,
  input  logic            rst_i,
  cpu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = '0;
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8);

  state_t           state;
  state_t           state_nxt;
  logic             req_r;
  logic             pc_we_r;
  logic             busy_r;
  logic             halted_r;
  logic             illegal_r;
  logic [CNT_W-1:0] retired;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI);
  endfunction

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = bus.start_i ? FETCH : IDLE;
      FETCH:   state_nxt = bus.imem_ack_i ? DECODE : FETCH;
      DECODE:  state_nxt = (bus.op_i != HALT_OP && op_supported(bus.op_i)) ? EXEC : HALT;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = bus.start_i ? FETCH : IDLE;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      req_r     <= 1'b0;
      pc_we_r   <= 1'b0;
      busy_r    <= 1'b0;
      halted_r  <= 1'b0;
      illegal_r <= 1'b0;
      retired   <= '0;
    end else begin
      state    <= state_nxt;
      req_r    <= (state_nxt == FETCH);
      pc_we_r  <= (state_nxt == WB);
      busy_r   <= (state_nxt == FETCH) || (state_nxt == DECODE) ||
                  (state_nxt == EXEC)  || (state_nxt == WB);
      halted_r <= (state_nxt == HALT);
      if (state == DECODE && bus.op_i != HALT_OP && !op_supported(bus.op_i))
        illegal_r <= 1'b1;
      if (state == WB)
        retired <= sat_inc(retired);
    end
  end

  // IR load follows the memory ack in the same cycle; reg writes follow Control in WB.
  assign bus.imem_req_o = req_r;
  assign bus.ir_we_o    = req_r & bus.imem_ack_i;
  assign bus.pc_we_o    = pc_we_r;
  assign bus.reg_we_o   = pc_we_r & bus.regwrite_i;
  assign bus.busy_o     = busy_r;
  assign bus.halted_o   = halted_r;
  assign bus.illegal_o  = illegal_r;
  assign bus.state_o    = state;
  assign bus.retired_o  = retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: instruction-step model compared every cycle plus directed literal checks.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       regwrite = 1'b0;
  logic       ack = 1'b0;
  logic [5:0] op = 6'd0;
  int         total = 0;
  int         passed = 0;
  bit         checking = 1'b0;

  cpu_sequencer_if #(.OP_W(6), .CNT_W(32)) bus32 ();
  cpu_sequencer_if #(.OP_W(6), .CNT_W(4))  bus4 ();

  assign bus32.start_i    = start;
  assign bus32.op_i       = op;
  assign bus32.regwrite_i = regwrite;
  assign bus32.imem_ack_i = ack;
  assign bus4.start_i     = start;
  assign bus4.op_i        = op;
  assign bus4.regwrite_i  = regwrite;
  assign bus4.imem_ack_i  = ack;

  cpu_sequencer #(.OP_W(6), .CNT_W(32), .HALT_OP(6'b111111)) dut32 (
    .clk_i(clk), .rst_i(rst_n), .bus(bus32));
  cpu_sequencer #(.OP_W(6), .CNT_W(4), .HALT_OP(6'b111111)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .bus(bus4));

  always #5 clk = ~clk;

  // Model: an instruction is in flight or not; step counts its phase (0 = fetching).
  bit running = 1'b0;
  bit stopped = 1'b0;
  bit ill     = 1'b0;
  int step    = 0;
  int count   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0; stopped <= 1'b0; ill <= 1'b0; step <= 0; count <= 0;
    end else if (!stopped) begin
      if (!running) begin
        if (start) begin running <= 1'b1; step <= 0; end
      end else if (step == 0) begin
        if (ack) step <= 1;
      end else if (step == 1) begin
        if (op == 6'b111111) begin
          running <= 1'b0; stopped <= 1'b1;
        end else if (op == 6'b000000 || op == 6'b001000) begin
          step <= 2;
        end else begin
          running <= 1'b0; stopped <= 1'b1; ill <= 1'b1;
        end
      end else if (step == 2) begin
        step <= 3;
      end else begin
        count <= count + 1;
        if (start) step <= 0;
        else running <= 1'b0;
      end
    end
  end

  function automatic logic [63:0] expv(input longint sat);
    logic [2:0] st;
    logic       req;
    logic       pcw;
    longint     c;
    st  = stopped ? 3'd5 : (running ? 3'(step + 1) : 3'd0);
    req = running && step == 0;
    pcw = running && step == 3;
    c   = (longint'(count) > sat) ? sat : longint'(count);
    return {22'd0, st, req, req && ack, pcw, pcw && regwrite, running, stopped, ill, 32'(c)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, want);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("cycle_w32", {22'd0, bus32.state_o, bus32.imem_req_o, bus32.ir_we_o, bus32.pc_we_o,
            bus32.reg_we_o, bus32.busy_o, bus32.halted_o, bus32.illegal_o, bus32.retired_o},
            expv(64'hFFFF_FFFF));
      check("cycle_w4", {22'd0, bus4.state_o, bus4.imem_req_o, bus4.ir_we_o, bus4.pc_we_o,
            bus4.reg_we_o, bus4.busy_o, bus4.halted_o, bus4.illegal_o, 28'd0, bus4.retired_o},
            expv(64'd15));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus32.state_o != 3'd0 && n < 30) begin
      cyc(1);
      n++;
    end
    check(name, 64'(bus32.state_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int pcw_cnt, regw_cnt, req_cnt, irwe_cnt, busy_cnt;
    #2 rst_n = 1'b0;
    checking = 1'b1;
    cyc(2);
    check("reset_state", {55'd0, bus32.state_o, bus32.busy_o, bus32.imem_req_o, bus32.pc_we_o,
          bus32.illegal_o, bus32.halted_o, bus32.ir_we_o}, 64'd0);
    check("reset_retired", 64'(bus32.retired_o), 64'd0);
    rst_n = 1'b1;
    cyc(1);

    // Zero-wait run of R-type instructions
    start = 1'b1; ack = 1'b1; op = 6'b000000; regwrite = 1'b1;
    cyc(1);
    check("t2_fetch_entry", 64'(bus32.state_o), 64'd1);
    pcw_cnt = 0; regw_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      pcw_cnt += int'(bus32.pc_we_o);
      regw_cnt += int'(bus32.reg_we_o);
      @(posedge clk); #1;
    end
    check("t2_pc_pulses", 64'(pcw_cnt), 64'd3);
    check("t2_reg_pulses", 64'(regw_cnt), 64'd3);
    check("t2_retired", 64'(bus32.retired_o), 64'd3);
    start = 1'b0;
    wait_idle("t2_idle");
    check("t2_retired4", 64'(bus32.retired_o), 64'd4);

    // Fetch with three wait cycles
    start = 1'b1; ack = 1'b0;
    cyc(1);
    req_cnt = 0; irwe_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      ack = (i == 3);
      if (i == 4) start = 1'b0;
      @(negedge clk);
      req_cnt += int'(bus32.imem_req_o);
      irwe_cnt += int'(bus32.ir_we_o);
      busy_cnt += int'(bus32.busy_o);
      @(posedge clk); #1;
    end
    check("t3_req_cycles", 64'(req_cnt), 64'd4);
    check("t3_irwe_cycles", 64'(irwe_cnt), 64'd1);
    check("t3_busy_cycles", 64'(busy_cnt), 64'd7);
    check("t3_idle", 64'(bus32.state_o), 64'd0);
    check("t3_retired", 64'(bus32.retired_o), 64'd5);

    // Pause on instruction boundary, then long run to saturate the narrow counter
    start = 1'b1; ack = 1'b1;
    cyc(3);
    check("t6_exec", 64'(bus32.state_o), 64'd3);
    start = 1'b0;
    cyc(1);
    check("t6_wb", 64'(bus32.pc_we_o), 64'd1);
    cyc(1);
    check("t6_paused", 64'(bus32.state_o), 64'd0);
    check("t6_retired", 64'(bus32.retired_o), 64'd6);
    cyc(2);
    check("t6_still_idle", 64'(bus32.state_o), 64'd0);
    start = 1'b1;
    cyc(1);
    check("t6_resume", 64'(bus32.state_o), 64'd1);
    cyc(80);
    start = 1'b0;
    wait_idle("t6_idle");
    check("t6_retired_w32", 64'(bus32.retired_o), 64'd27);
    check("t6_sat_w4", 64'(bus4.retired_o), 64'd15);

    // addi retires, then an unsupported opcode halts with illegal set
    start = 1'b1; op = 6'b001000; regwrite = 1'b1;
    cyc(4);
    check("t5_addi_regwe", {62'd0, bus32.reg_we_o, bus32.pc_we_o}, 64'd3);
    cyc(1);
    op = 6'b100011;
    cyc(2);
    check("t5_halt_state", {60'd0, bus32.state_o, bus32.illegal_o}, {60'd0, 3'd5, 1'b1});
    check("t5_halted", 64'(bus32.halted_o), 64'd1);
    check("t5_retired", 64'(bus32.retired_o), 64'd28);

    start = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    check("rst_clears_illegal", {63'd0, bus32.illegal_o}, 64'd0);
    check("rst_clears_retired", 64'(bus32.retired_o), 64'd0);

    // Halt opcode: stop cleanly, start ignored afterwards
    start = 1'b1; op = 6'b111111; ack = 1'b1;
    cyc(3);
    check("t4_halt", {57'd0, bus32.state_o, bus32.halted_o, bus32.illegal_o, bus32.busy_o,
          bus32.pc_we_o}, {57'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 6; i++) begin
      start = ~start;
      cyc(1);
    end
    check("t4_stays_halted", 64'(bus32.state_o), 64'd5);
    check("t4_retired", 64'(bus32.retired_o), 64'd0);

    // Asynchronous reset in the middle of EXEC
    start = 1'b0;
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    start = 1'b1; op = 6'b000000; ack = 1'b1;
    cyc(7);
    check("t1_in_exec", 64'(bus32.state_o), 64'd3);
    check("t1_retired_before", 64'(bus32.retired_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_state", 64'(bus32.state_o), 64'd0);
    check("t1_async_strobes", {60'd0, bus32.imem_req_o, bus32.ir_we_o, bus32.pc_we_o,
          bus32.reg_we_o}, 64'd0);
    check("t1_async_retired", 64'(bus32.retired_o), 64'd0);
    start = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    check("t1_idle_after", 64'(bus32.state_o), 64'd0);

    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
